// File: rtl/vr16_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vr16_pkg
// Brief    : Shared VR16 fetch-path widths, typedefs and the fetch entry struct.
// Revision : 1.0 - initial release
// ============================================================================
package vr16_pkg;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 16;

    typedef logic [INSTR_W-1:0] instr_t;
    typedef logic [ADDR_W-1:0]  addr_t;

    typedef struct packed {
        instr_t instr;
        addr_t  addr;
    } fetch_entry_t;

    function automatic fetch_entry_t make_entry(input instr_t instr, input addr_t addr);
        fetch_entry_t e;
        e.instr = instr;
        e.addr  = addr;
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_buffer_mem.sv
`default_nettype none
// ============================================================================
// Module   : fetch_buffer_mem
// Brief    : DEPTH x WIDTH register array, one write port, one async read port.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_buffer_mem
    import vr16_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = vr16_pkg::INSTR_W + vr16_pkg::ADDR_W
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are intentionally left unreset; validity is tracked by the owner.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_buffer
// Brief    : Instruction prefetch FIFO between instruction memory and decoder.
//            Optional FETCH_BUFFER_STATS_EN adds starve_count and overflow_err.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_buffer
    import vr16_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int INSTR_W = vr16_pkg::INSTR_W,
    parameter int ADDR_W  = vr16_pkg::ADDR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    output logic                     fetch_enable,
    input  logic                     in_valid,
    input  logic [INSTR_W-1:0]       in_instr,
    input  logic [ADDR_W-1:0]        in_addr,
    output logic                     out_valid,
    output logic [INSTR_W-1:0]       out_instr,
    output logic [ADDR_W-1:0]        out_addr,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
`ifdef FETCH_BUFFER_STATS_EN
    ,
    output logic [15:0]              starve_count,
    output logic                     overflow_err
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = INSTR_W + ADDR_W;

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          pending;
    logic          discard;
    logic          running;
    logic          full;
    logic          push_try;
    logic          push;
    logic          pop;
    logic [EW-1:0] rd_data;

    assign full     = (count == CW'(DEPTH));
    assign pop      = out_valid && out_ready && !flush;
    assign push_try = in_valid && !discard && !flush;
    // A push into a full buffer is only legal when the head leaves the same cycle.
    assign push     = push_try && (!full || pop);

    // Every in-flight read owns a slot, so accepted data can never overflow.
    assign fetch_enable = running && !flush && ((count + CW'(pending)) < CW'(DEPTH));

    assign out_valid = (count != '0);
    assign out_instr = out_valid ? rd_data[EW-1:ADDR_W] : '0;
    assign out_addr  = out_valid ? rd_data[ADDR_W-1:0]  : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            running <= 1'b0;
            pending <= 1'b0;
            discard <= 1'b0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
        end else begin
            running <= 1'b1;
            if (flush) begin
                pending <= 1'b0;
                discard <= pending;
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                count   <= '0;
            end else begin
                pending <= fetch_enable;
                discard <= 1'b0;
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push && !pop) begin
                    count <= count + 1'b1;
                end else if (pop && !push) begin
                    count <= count - 1'b1;
                end
            end
        end
    end

    fetch_buffer_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data ({in_instr, in_addr}),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

`ifdef FETCH_BUFFER_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_count <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (out_ready && !out_valid && !flush && (starve_count != 16'hFFFF)) begin
                starve_count <= starve_count + 16'd1;
            end
            if (push_try && full && !pop) begin
                overflow_err <= 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_buffer
// Brief    : Scoreboard bench for fetch_buffer with a 1-cycle-latency memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_buffer;
    import vr16_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        fetch_enable;
    logic        in_valid;
    logic [15:0] in_instr;
    logic [15:0] in_addr;
    logic        out_valid;
    logic [15:0] out_instr;
    logic [15:0] out_addr;
    logic        out_ready;
    logic [2:0]  count;
`ifdef FETCH_BUFFER_STATS_EN
    logic [15:0] starve_count;
    logic        overflow_err;
`endif

    fetch_buffer #(.DEPTH(4), .INSTR_W(16), .ADDR_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .fetch_enable (fetch_enable),
        .in_valid     (in_valid),
        .in_instr     (in_instr),
        .in_addr      (in_addr),
        .out_valid    (out_valid),
        .out_instr    (out_instr),
        .out_addr     (out_addr),
        .out_ready    (out_ready),
        .count        (count)
`ifdef FETCH_BUFFER_STATS_EN
        ,
        .starve_count (starve_count),
        .overflow_err (overflow_err)
`endif
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            max_cnt  = 0;
    fetch_entry_t  exp_q[$];

    logic          stall = 1'b0;
    logic          poison = 1'b0;
    logic          redirect = 1'b0;
    logic [15:0]   redirect_pc = 16'h0;
    logic          force_valid = 1'b0;
    logic          force_noexp = 1'b0;
    logic [15:0]   force_instr = 16'h0;
    logic [15:0]   force_addr = 16'h0;

    // Program image: 0x1001.. at 0x0000, 0x2000.. at 0x0040.
    function automatic logic [15:0] instr_at(input logic [15:0] a);
        if (a < 16'h0040) return 16'h1001 + a;
        return 16'h2000 + (a - 16'h0040);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory model: answers each fetch_enable one cycle later.
    initial begin
        logic        fe_s;
        logic [15:0] pc;
        pc       = 16'h0;
        in_valid = 1'b0;
        in_instr = 16'h0;
        in_addr  = 16'h0;
        forever begin
            @(negedge clk);
            fe_s = fetch_enable;
            @(posedge clk);
            #1;
            if (!reset) begin
                in_valid = 1'b0;
                pc       = 16'h0;
                exp_q.delete();
            end else if (force_valid) begin
                in_valid = 1'b1;
                in_instr = force_instr;
                in_addr  = force_addr;
                if (!force_noexp) exp_q.push_back(make_entry(force_instr, force_addr));
                force_valid = 1'b0;
            end else if (fe_s && !stall) begin
                in_valid = 1'b1;
                in_addr  = pc;
                in_instr = poison ? 16'hDEAD : instr_at(pc);
                if (!poison) exp_q.push_back(make_entry(instr_at(pc), pc));
                poison = 1'b0;
                pc     = pc + 16'h1;
            end else begin
                in_valid = 1'b0;
            end
            if (redirect) begin
                pc       = redirect_pc;
                redirect = 1'b0;
                exp_q.delete();
            end
        end
    end

    // Monitor: pops the scoreboard on every accepted head.
    initial begin
        fetch_entry_t e;
        forever begin
            @(negedge clk);
            if (reset && out_valid && out_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got 0x%0h@0x%0h, expected no output", out_instr, out_addr);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_instr", 32'(out_instr), 32'(e.instr));
                    check("sb_addr", 32'(out_addr), 32'(e.addr));
                end
            end
            if (reset && int'(count) > max_cnt) max_cnt = int'(count);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   fe_cnt;
        logic found;
        reset     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_count", 32'(count), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_fe", 32'(fetch_enable), 32'd0);
        check("rst_instr", 32'(out_instr), 32'd0);
        check("rst_addr", 32'(out_addr), 32'd0);

        // Release with decoder stalled: exactly four reads fill the buffer.
        @(posedge clk);
        #2 reset = 1'b1;
        fe_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (fetch_enable) fe_cnt++;
        end
        check("fill_fe_cycles", 32'(fe_cnt), 32'd4);
        check("fill_count", 32'(count), 32'd4);
        check("fill_valid", 32'(out_valid), 32'd1);
        check("fill_instr", 32'(out_instr), 32'h1001);
        check("fill_addr", 32'(out_addr), 32'h0000);

        // Drain four; fetch resumes the cycle after the first pop.
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("refill_hold_fe", 32'(fetch_enable), 32'd0);
        @(negedge clk);
        check("refill_resume_fe", 32'(fetch_enable), 32'd1);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (8) @(negedge clk);
        check("refill_full", 32'(count), 32'd4);

        // Push and pop together at full.
        force_instr = 16'h3333;
        force_addr  = 16'h0099;
        force_noexp = 1'b0;
        force_valid = 1'b1;
        @(posedge clk);
        #2 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("pushpop_full_count", 32'(count), 32'd4);
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (8) @(negedge clk);

        // Flush to empty and refill from 0x0020.
        redirect_pc = 16'h0020;
        redirect    = 1'b1;
        @(posedge clk);
        #2 flush = 1'b1;
        @(posedge clk);
        #2 flush = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (count == 3'd2 && fetch_enable) found = 1'b1;
        end
        check("flush_setup_found", 32'(found), 32'd1);

        // Flush with count=3, pending=1; the in-flight word is 0xDEAD.
        poison      = 1'b1;
        redirect_pc = 16'h0040;
        redirect    = 1'b1;
        @(posedge clk);
        #2 flush = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #2 flush = 1'b0;
        @(negedge clk);
        check("flush_count", 32'(count), 32'd0);
        check("flush_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("flush_gap_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("flush_head_valid", 32'(out_valid), 32'd1);
        check("flush_head_instr", 32'(out_instr), 32'h2000);
        check("flush_head_addr", 32'(out_addr), 32'h0040);

        // Streaming with the decoder always ready: no bubbles.
        repeat (20) begin
            @(negedge clk);
            check("steady_valid", 32'(out_valid), 32'd1);
        end

        // Asynchronous reset between clock edges.
        @(posedge clk);
        #3 reset = 1'b0;
        out_ready = 1'b0;
        #1;
        check("async_count", 32'(count), 32'd0);
        check("async_valid", 32'(out_valid), 32'd0);
        check("async_fe", 32'(fetch_enable), 32'd0);
        check("async_instr", 32'(out_instr), 32'd0);
        check("async_addr", 32'(out_addr), 32'd0);
        stall = 1'b1;
        @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        check("release_fe_before_edge", 32'(fetch_enable), 32'd0);
        @(negedge clk);
        check("release_fe_after_edge", 32'(fetch_enable), 32'd1);

`ifdef FETCH_BUFFER_STATS_EN
        check("stats_starve_init", 32'(starve_count), 32'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1 out_ready = 1'b0;
        check("stats_starve_10", 32'(starve_count), 32'd10);
        force_noexp = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            force_instr = 16'h4000 + 16'(i);
            force_addr  = 16'h0100 + 16'(i);
            force_valid = 1'b1;
        end
        @(negedge clk);
        check("stats_full_count", 32'(count), 32'd4);
        check("stats_ovf_clear", 32'(overflow_err), 32'd0);
        @(negedge clk);
        check("stats_ovf_set", 32'(overflow_err), 32'd1);
        check("stats_ovf_count", 32'(count), 32'd4);
`endif

        check("max_count_le_depth", 32'(max_cnt <= 4), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Small instruction prefetch FIFO between instruction_memory and instruction_decoder.
- Issues memory read enables ahead of the decoder, which lets the fetch pipeline stay busy while the decoder stalls.
- Each instruction is held with its fetch address.
- Discards everything on a jump/return flush so the decoder never sees a wrong-path instruction.

Parameters:
- DEPTH, 4, number of buffered entries; power of two, >= 2
- INSTR_W, 16, instruction width
- ADDR_W, 16, fetch address width (matches counter_reg)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- flush  input  1  jump/return taken; discard all buffered and in-flight instructions
- fetch_enable  output  1  read enable to instruction_memory; also the advance permission for program_counter
- in_valid  input  1  instruction_memory data valid (one cycle after fetch_enable)
- in_instr  input  INSTR_W  fetched instruction
- in_addr  input  ADDR_W  address the instruction was fetched from
- out_valid  output  1  head entry available to decoder
- out_instr  output  INSTR_W  head instruction
- out_addr  output  ADDR_W  head address
- out_ready  input  1  decoder accepts head this cycle
- count  output  $clog2(DEPTH)+1  entries currently stored

Behaviour:
- Reset (reset=0, async):
  - count=0, out_valid=0, out_instr=0, out_addr=0, fetch_enable=0.
  - pending=0, discard=0, read/write pointers=0.
  - Storage contents are not reset.
- Pointers: rd_ptr and wr_ptr are $clog2(DEPTH) bits, wrap modulo DEPTH. count distinguishes full from empty.
- pending: 1-bit register, equal to fetch_enable delayed one cycle (memory latency 1).
- fetch_enable (combinational) = reset_released && !flush && (count + pending) < DEPTH. This reserves a slot for every in-flight read, so an accepted read never overflows.
- Push: in_valid && !discard && !flush writes {in_instr, in_addr} at wr_ptr, then wr_ptr++.
  - in_valid while the buffer is full and no slot is reserved is a protocol violation. Data is dropped, state is unchanged.
- Pop: out_valid && out_ready && !flush advances rd_ptr.
- out_valid = (count != 0); out_instr/out_addr = entry at rd_ptr (registered storage read, no bypass).
- Latency: a push into an empty buffer makes out_valid=1 the following cycle. No same-cycle in→out bypass.
- Simultaneous push+pop: allowed at any count, including full (push legal because its slot was reserved); count unchanged.
- Flush (highest priority, synchronous):
  - Next cycle: count=0, rd_ptr=wr_ptr=0, pending=0, out_valid=0.
  - A push or pop in the same cycle is ignored.
  - discard is set to the value of pending at the flush edge.
- discard: while set, the next in_valid is dropped and discard clears. If no in_valid arrives, discard clears on the next cycle anyway, since memory latency is exactly 1.
- fetch_enable resumes the cycle after flush deasserts.
- Reset mid-operation: immediate return to the reset state. The first fetch_enable follows the first clock edge after reset release.

Optional Feature:
- Macro FETCH_BUFFER_STATS_EN.
- Defined:
  - Adds output starve_count[15:0].
  - Increments every cycle with out_ready=1 && out_valid=0 && !flush; saturates at 16'hFFFF.
  - Cleared only by reset.
  - Also adds output overflow_err (sticky, 1 bit), set when a push is attempted with count==DEPTH and no simultaneous pop; cleared only by reset.
- Undefined: both ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package vr16_pkg holds:
  - INSTR_W=16 and ADDR_W=16 constants.
  - instr_t/addr_t typedefs.
  - A fetch_entry_t struct {instr_t instr; addr_t addr}, reused by decoder and pipeline registers.
- One natural sub-module: fetch_buffer_mem.
  - DEPTH x (INSTR_W+ADDR_W) register array.
  - One write port, one combinational read port, no reset.
  - Pointers, count and control stay in fetch_buffer.

Test Plan:
- Reset hold, then release with out_ready=0:
  - fetch_enable=1 for exactly 4 cycles, then 0.
  - Memory returns 0x1001..0x1004 at addresses 0..3; count reaches 4, out_valid=1, out_instr=0x1001, out_addr=0.
- Full buffer, out_ready=1 for 4 cycles: pops 0x1001..0x1004 in order. fetch_enable reasserts the cycle after the first pop. count never exceeds 4.
- Steady state with out_ready=1 continuously: one instruction delivered per cycle after the 2-cycle fill latency, with no gaps.
- Flush asserted while pending=1 and count=3:
  - Next cycle count=0, out_valid=0.
  - The in-flight word 0xDEAD is dropped.
  - The first post-flush fetch (0x2000 @ 0x0040) appears as the head.
- Push and pop in the same cycle at count=4: count stays 4, order preserved. Async reset asserted mid-stream: all outputs 0 without waiting for a clock edge.
- FETCH_BUFFER_STATS_EN defined, empty buffer, out_ready=1 for 10 cycles with memory stalled (in_valid=0): starve_count=10; forcing a push at count=4 sets overflow_err=1.
